rob_dispatch_ctrl: RTL and testbench



---
 rtl/rob_dispatch_pkg.sv | 38 +++
 rtl/rob_dispatch_ctrl_slot_buf.sv | 56 +++++
 rtl/rob_dispatch_ctrl.sv | 159 +++++++++++++++
 tb/tb_rob_dispatch_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_dispatch_pkg.sv
// Shared types for the rename-to-ROB dispatch sequencer: ROB state codes,
// dispatch FSM codes and the buffered dispatch-slot layout.
package rob_dispatch_pkg;

    localparam int DISP_ROB_SIZE_LOG = 6;
    localparam int DISP_PC_W         = 64;
    localparam int DISP_LREG_W       = 5;
    localparam int DISP_PREG_W       = 6;

    localparam logic [1:0] ROB_IDLE = 2'b00;
    localparam logic [1:0] ROB_WALK = 2'b01;

    typedef logic [1:0] disp_state_t;
    localparam disp_state_t DISP_RUN   = 2'd0;
    localparam disp_state_t DISP_FLUSH = 2'd1;
    localparam disp_state_t DISP_WALK  = 2'd2;

    typedef struct packed {
        logic [DISP_PC_W-1:0]   pc;
        logic [31:0]            instr;
        logic [DISP_LREG_W-1:0] lrd;
        logic [DISP_PREG_W-1:0] prd;
        logic [DISP_PREG_W-1:0] old_prd;
        logic                   need_to_wb;
        logic                   is_store;
    } disp_payload_t;

    typedef struct packed {
        logic          v;
        disp_payload_t p;
    } disp_slot_t;

    // A slot can leave when its issue-queue port and, for stores, the store queue accept it.
    function automatic logic slot_can_go(disp_slot_t s, logic iq_ok, logic sq_ok);
        return s.v & iq_ok & (!s.p.is_store | sq_ok);
    endfunction

endpackage

// File: rtl/rob_dispatch_ctrl_slot_buf.sv
// Two-entry in-order dispatch buffer (dispatch_slot_buf): partial-dispatch shift,
// group load with slot-1-only compaction, and flush/reset clearing.
module dispatch_slot_buf
    import rob_dispatch_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       flush,
    input  logic       accept,
    input  logic       deq0,
    input  logic       deq1,
    input  disp_slot_t rn0,
    input  disp_slot_t rn1,
    output disp_slot_t s0,
    output disp_slot_t s1,
    output logic       drained
);

    disp_slot_t after0;
    disp_slot_t after1;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        after0 = s0;
        after1 = s1;
        if (deq1) begin
            after0 = '0;
            after1 = '0;
        end else if (deq0) begin
            after0 = s1;
            after1 = '0;
        end
    end

    assign drained = !after0.v && !after1.v;

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset || flush) begin
            s0 <= '0;
            s1 <= '0;
        end else if (accept) begin
            if (rn0.v) begin
                s0 <= rn0;
                s1 <= rn1;
            end else begin
                s0 <= rn1;
                s1 <= '0;
            end
        end else begin
            s0 <= after0;
            s1 <= after1;
        end
    end

endmodule

// File: rtl/rob_dispatch_ctrl.sv
// Rename-to-ROB dispatch sequencer: buffers one two-wide rename group and enqueues it
// in order into the ROB. Optional stall counters enabled by DISPATCH_PERF_EN.
module rob_dispatch_ctrl
    import rob_dispatch_pkg::*;
#(
    parameter int ROB_SIZE_LOG = DISP_ROB_SIZE_LOG,
    parameter int PC_W         = DISP_PC_W,
    parameter int LREG_W       = DISP_LREG_W,
    parameter int PREG_W       = DISP_PREG_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rn_instr0_valid,
    input  logic [PC_W-1:0]       rn_instr0_pc,
    input  logic [31:0]           rn_instr0,
    input  logic [LREG_W-1:0]     rn_instr0_lrd,
    input  logic [PREG_W-1:0]     rn_instr0_prd,
    input  logic [PREG_W-1:0]     rn_instr0_old_prd,
    input  logic                  rn_instr0_need_to_wb,
    input  logic                  rn_instr0_is_store,
    input  logic                  rn_instr1_valid,
    input  logic [PC_W-1:0]       rn_instr1_pc,
    input  logic [31:0]           rn_instr1,
    input  logic [LREG_W-1:0]     rn_instr1_lrd,
    input  logic [PREG_W-1:0]     rn_instr1_prd,
    input  logic [PREG_W-1:0]     rn_instr1_old_prd,
    input  logic                  rn_instr1_need_to_wb,
    input  logic                  rn_instr1_is_store,
    output logic                  rn_ready,
    input  logic                  iq_can_alloc0,
    input  logic                  iq_can_alloc1,
    input  logic                  sq_can_alloc,
    input  logic [ROB_SIZE_LOG:0] rob_counter,
    input  logic [1:0]            rob_state,
    input  logic                  flush_valid,
    output logic                  instr0_enq_valid,
    output logic [PC_W-1:0]       instr0_pc,
    output logic [31:0]           instr0,
    output logic [LREG_W-1:0]     instr0_lrd,
    output logic [PREG_W-1:0]     instr0_prd,
    output logic [PREG_W-1:0]     instr0_old_prd,
    output logic                  instr0_need_to_wb,
    output logic                  instr1_enq_valid,
    output logic [PC_W-1:0]       instr1_pc,
    output logic [31:0]           instr1,
    output logic [LREG_W-1:0]     instr1_lrd,
    output logic [PREG_W-1:0]     instr1_prd,
    output logic [PREG_W-1:0]     instr1_old_prd,
    output logic                  instr1_need_to_wb
`ifdef DISPATCH_PERF_EN
    ,
    output logic [31:0]           perf_stall_rob,
    output logic [31:0]           perf_stall_iq,
    output logic [31:0]           perf_stall_sq
`endif
);

    localparam int               RC_W        = ROB_SIZE_LOG + 1;
    localparam logic [RC_W-1:0]  ROB_ENTRIES = RC_W'(1) << ROB_SIZE_LOG;

    disp_state_t     state;
    disp_slot_t      rn0, rn1, s0, s1;
    logic [RC_W-1:0] free;
    logic            ok0, ok1, run_gate, drained;

    always_comb begin
        rn0 = '0;
        rn0.v            = rn_instr0_valid;
        rn0.p.pc         = rn_instr0_pc;
        rn0.p.instr      = rn_instr0;
        rn0.p.lrd        = rn_instr0_lrd;
        rn0.p.prd        = rn_instr0_prd;
        rn0.p.old_prd    = rn_instr0_old_prd;
        rn0.p.need_to_wb = rn_instr0_need_to_wb;
        rn0.p.is_store   = rn_instr0_is_store;
        rn1 = '0;
        rn1.v            = rn_instr1_valid;
        rn1.p.pc         = rn_instr1_pc;
        rn1.p.instr      = rn_instr1;
        rn1.p.lrd        = rn_instr1_lrd;
        rn1.p.prd        = rn_instr1_prd;
        rn1.p.old_prd    = rn_instr1_old_prd;
        rn1.p.need_to_wb = rn_instr1_need_to_wb;
        rn1.p.is_store   = rn_instr1_is_store;
    end

    // rob_counter is pre-enqueue; commits only add space, so this bound is conservative.
    assign free     = ROB_ENTRIES - rob_counter;
    assign ok0      = slot_can_go(s0, iq_can_alloc0, sq_can_alloc) && (free != '0);
    assign ok1      = ok0 && slot_can_go(s1, iq_can_alloc1, sq_can_alloc) && (free > RC_W'(1));
    assign run_gate = (state == DISP_RUN) && !flush_valid;

    assign instr0_enq_valid = ok0 && run_gate;
    assign instr1_enq_valid = ok1 && run_gate;
    assign rn_ready         = run_gate && !reset && drained;

    dispatch_slot_buf u_slot_buf (
        .clock   (clock),
        .reset   (reset),
        .flush   (flush_valid),
        .accept  (rn_ready),
        .deq0    (instr0_enq_valid),
        .deq1    (instr1_enq_valid),
        .rn0     (rn0),
        .rn1     (rn1),
        .s0      (s0),
        .s1      (s1),
        .drained (drained)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= DISP_RUN;
        end else if (flush_valid) begin
            state <= DISP_FLUSH;
        end else begin
            case (state)
                DISP_FLUSH: state <= DISP_WALK;
                DISP_WALK:  state <= (rob_state == ROB_IDLE) ? DISP_RUN : DISP_WALK;
                default:    state <= DISP_RUN;
            endcase
        end
    end

    assign instr0_pc         = s0.p.pc;
    assign instr0            = s0.p.instr;
    assign instr0_lrd        = s0.p.lrd;
    assign instr0_prd        = s0.p.prd;
    assign instr0_old_prd    = s0.p.old_prd;
    assign instr0_need_to_wb = s0.p.need_to_wb;
    assign instr1_pc         = s1.p.pc;
    assign instr1            = s1.p.instr;
    assign instr1_lrd        = s1.p.lrd;
    assign instr1_prd        = s1.p.prd;
    assign instr1_old_prd    = s1.p.old_prd;
    assign instr1_need_to_wb = s1.p.need_to_wb;

`ifdef DISPATCH_PERF_EN
    // Each stalled RUN cycle is charged to one reason only, ROB first, then IQ, then SQ.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_rob <= '0;
            perf_stall_iq  <= '0;
            perf_stall_sq  <= '0;
        end else if (state == DISP_RUN && s0.v && !instr0_enq_valid) begin
            if (free == '0) begin
                if (perf_stall_rob != '1) perf_stall_rob <= perf_stall_rob + 32'd1;
            end else if (!iq_can_alloc0) begin
                if (perf_stall_iq != '1) perf_stall_iq <= perf_stall_iq + 32'd1;
            end else if (s0.p.is_store && !sq_can_alloc) begin
                if (perf_stall_sq != '1) perf_stall_sq <= perf_stall_sq + 32'd1;
            end
        end
    end
`else
    // Stall counters are not built; dispatch behaviour is unchanged.
`endif

endmodule

// File: tb/tb_rob_dispatch_ctrl.sv
// Self-checking bench for rob_dispatch_ctrl: directed scenarios followed by randomized
// traffic, all compared against a queue-based model of the dispatch rules.
module tb_rob_dispatch_ctrl;

    localparam int RSL     = 6;
    localparam int ENTRIES = 1 << RSL;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] word;
        logic [4:0]  lrd;
        logic [5:0]  prd;
        logic [5:0]  old_prd;
        logic        wb;
        logic        st;
    } ins_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        rn_instr0_valid, rn_instr1_valid;
    logic [63:0] rn_instr0_pc, rn_instr1_pc;
    logic [31:0] rn_instr0, rn_instr1;
    logic [4:0]  rn_instr0_lrd, rn_instr1_lrd;
    logic [5:0]  rn_instr0_prd, rn_instr1_prd, rn_instr0_old_prd, rn_instr1_old_prd;
    logic        rn_instr0_need_to_wb, rn_instr1_need_to_wb;
    logic        rn_instr0_is_store, rn_instr1_is_store;
    logic        rn_ready;
    logic        iq_can_alloc0, iq_can_alloc1, sq_can_alloc;
    logic [RSL:0] rob_counter;
    logic [1:0]  rob_state;
    logic        flush_valid;
    logic        instr0_enq_valid, instr1_enq_valid;
    logic [63:0] instr0_pc, instr1_pc;
    logic [31:0] instr0, instr1;
    logic [4:0]  instr0_lrd, instr1_lrd;
    logic [5:0]  instr0_prd, instr1_prd, instr0_old_prd, instr1_old_prd;
    logic        instr0_need_to_wb, instr1_need_to_wb;
`ifdef DISPATCH_PERF_EN
    logic [31:0] perf_stall_rob, perf_stall_iq, perf_stall_sq;
`endif

    rob_dispatch_ctrl dut (
        .clock(clock), .reset(reset),
        .rn_instr0_valid(rn_instr0_valid), .rn_instr0_pc(rn_instr0_pc), .rn_instr0(rn_instr0),
        .rn_instr0_lrd(rn_instr0_lrd), .rn_instr0_prd(rn_instr0_prd),
        .rn_instr0_old_prd(rn_instr0_old_prd), .rn_instr0_need_to_wb(rn_instr0_need_to_wb),
        .rn_instr0_is_store(rn_instr0_is_store),
        .rn_instr1_valid(rn_instr1_valid), .rn_instr1_pc(rn_instr1_pc), .rn_instr1(rn_instr1),
        .rn_instr1_lrd(rn_instr1_lrd), .rn_instr1_prd(rn_instr1_prd),
        .rn_instr1_old_prd(rn_instr1_old_prd), .rn_instr1_need_to_wb(rn_instr1_need_to_wb),
        .rn_instr1_is_store(rn_instr1_is_store),
        .rn_ready(rn_ready),
        .iq_can_alloc0(iq_can_alloc0), .iq_can_alloc1(iq_can_alloc1), .sq_can_alloc(sq_can_alloc),
        .rob_counter(rob_counter), .rob_state(rob_state), .flush_valid(flush_valid),
        .instr0_enq_valid(instr0_enq_valid), .instr0_pc(instr0_pc), .instr0(instr0),
        .instr0_lrd(instr0_lrd), .instr0_prd(instr0_prd), .instr0_old_prd(instr0_old_prd),
        .instr0_need_to_wb(instr0_need_to_wb),
        .instr1_enq_valid(instr1_enq_valid), .instr1_pc(instr1_pc), .instr1(instr1),
        .instr1_lrd(instr1_lrd), .instr1_prd(instr1_prd), .instr1_old_prd(instr1_old_prd),
        .instr1_need_to_wb(instr1_need_to_wb)
`ifdef DISPATCH_PERF_EN
        ,
        .perf_stall_rob(perf_stall_rob), .perf_stall_iq(perf_stall_iq),
        .perf_stall_sq(perf_stall_sq)
`endif
    );

    always #5 clock = ~clock;

    int   n_asserts = 0;
    int   n_fail    = 0;

    // Reference model: pending instructions in program order plus the flush/walk phase.
    ins_t mq[$];
    bit   m_run      = 1'b1;
    bit   m_flushcyc = 1'b0;
    int   exp_n;
    bit   exp_ready;
    ins_t g0, g1;
    bit   gv0, gv1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ins_t rand_ins(input bit allow_store);
        ins_t r;
        r.pc      = {$urandom, $urandom};
        r.word    = $urandom;
        r.lrd     = 5'($urandom);
        r.prd     = 6'($urandom);
        r.old_prd = 6'($urandom);
        r.wb      = 1'($urandom);
        r.st      = allow_store && ($urandom_range(0, 3) == 0);
        return r;
    endfunction

    task automatic drive_group(input bit v0, input ins_t a, input bit v1, input ins_t b);
        gv0 = v0; g0 = a; gv1 = v1; g1 = b;
        rn_instr0_valid = v0; rn_instr0_pc = a.pc; rn_instr0 = a.word; rn_instr0_lrd = a.lrd;
        rn_instr0_prd = a.prd; rn_instr0_old_prd = a.old_prd;
        rn_instr0_need_to_wb = a.wb; rn_instr0_is_store = a.st;
        rn_instr1_valid = v1; rn_instr1_pc = b.pc; rn_instr1 = b.word; rn_instr1_lrd = b.lrd;
        rn_instr1_prd = b.prd; rn_instr1_old_prd = b.old_prd;
        rn_instr1_need_to_wb = b.wb; rn_instr1_is_store = b.st;
    endtask

    task automatic model_check();
        int  free;
        bit  iq;
        free  = ENTRIES - int'(rob_counter);
        exp_n = 0;
        if (m_run && !flush_valid) begin
            for (int i = 0; i < mq.size(); i++) begin
                iq = (i == 0) ? iq_can_alloc0 : iq_can_alloc1;
                if (free >= i + 1 && iq && (!mq[i].st || sq_can_alloc)) exp_n++;
                else break;
            end
        end
        exp_ready = !reset && m_run && !flush_valid && (mq.size() == exp_n);
        check("enq0", instr0_enq_valid, exp_n >= 1);
        check("enq1", instr1_enq_valid, exp_n >= 2);
        check("rn_ready", rn_ready, exp_ready);
        if (mq.size() >= 1) begin
            check("pc0", instr0_pc, mq[0].pc);
            check("word0", instr0, mq[0].word);
            check("regs0", {instr0_lrd, instr0_prd, instr0_old_prd, instr0_need_to_wb},
                  {mq[0].lrd, mq[0].prd, mq[0].old_prd, mq[0].wb});
        end
        if (mq.size() >= 2) begin
            check("pc1", instr1_pc, mq[1].pc);
            check("word1", instr1, mq[1].word);
            check("regs1", {instr1_lrd, instr1_prd, instr1_old_prd, instr1_need_to_wb},
                  {mq[1].lrd, mq[1].prd, mq[1].old_prd, mq[1].wb});
        end
    endtask

    task automatic model_update();
        if (reset) begin
            mq.delete();
            m_run = 1'b1; m_flushcyc = 1'b0;
        end else if (flush_valid) begin
            mq.delete();
            m_run = 1'b0; m_flushcyc = 1'b1;
        end else if (m_run) begin
            for (int i = 0; i < exp_n; i++) void'(mq.pop_front());
            if (exp_ready) begin
                if (gv0) mq.push_back(g0);
                if (gv1) mq.push_back(g1);
            end
        end else if (m_flushcyc) begin
            m_flushcyc = 1'b0;
        end else if (rob_state == 2'b00) begin
            m_run = 1'b1;
        end
    endtask

    // Called just after a falling edge with inputs set; returns at the next falling edge.
    task automatic cycle();
        #1;
        model_check();
        model_update();
        @(negedge clock);
    endtask

    initial begin
        ins_t a, b, none;
        none = '{default: '0};
        reset = 1'b1; flush_valid = 1'b0; rob_state = 2'b00; rob_counter = '0;
        iq_can_alloc0 = 1'b1; iq_can_alloc1 = 1'b1; sq_can_alloc = 1'b1;
        drive_group(0, none, 0, none);
        @(negedge clock);

        // Reset held: everything quiet, payload cleared.
        #1;
        check("rst_ready", rn_ready, 1'b0);
        check("rst_enq", {instr0_enq_valid, instr1_enq_valid}, 2'b00);
        check("rst_pc0", instr0_pc, 64'd0);
        check("rst_word1", instr1, 32'd0);
        cycle();
        reset = 1'b0;

        // Two-wide group, empty ROB: accept now, both enqueue next cycle.
        a = rand_ins(0); b = rand_ins(0);
        drive_group(1, a, 1, b);
        #1 check("basic_ready", rn_ready, 1'b1);
        cycle();
        drive_group(0, none, 0, none);
        #1;
        check("basic_enq", {instr0_enq_valid, instr1_enq_valid}, 2'b11);
        check("basic_pc1", instr1_pc, b.pc);
        cycle();

        // One free entry: only s0 goes, s1 shifts down; a full ROB then holds it.
        a = rand_ins(0); b = rand_ins(0);
        drive_group(1, a, 1, b);
        cycle();
        drive_group(1, rand_ins(0), 1, rand_ins(0));
        rob_counter = 7'd63;
        #1 check("free1_enq", {instr0_enq_valid, instr1_enq_valid}, 2'b10);
        cycle();
        rob_counter = 7'd64;
        #1;
        check("full_enq", instr0_enq_valid, 1'b0);
        check("full_pc0", instr0_pc, b.pc);
        cycle();
        cycle();
        drive_group(0, none, 0, none);
        rob_counter = 7'd0;
        #1 check("drain_enq", instr0_enq_valid, 1'b1);
        cycle();

        // s1 store blocked by the store queue, released the cycle after.
        a = rand_ins(0); b = rand_ins(0); b.st = 1'b1;
        drive_group(1, a, 1, b);
        cycle();
        drive_group(0, none, 0, none);
        sq_can_alloc = 1'b0;
        #1 check("sq_block", {instr0_enq_valid, instr1_enq_valid}, 2'b10);
        cycle();
        sq_can_alloc = 1'b1;
        #1;
        check("sq_release", instr0_enq_valid, 1'b1);
        check("sq_pc", instr0_pc, b.pc);
        cycle();

        // Flush beats a ready dispatch; rename stays blocked through FLUSH and WALK.
        drive_group(1, rand_ins(0), 1, rand_ins(0));
        cycle();
        drive_group(0, none, 0, none);
        flush_valid = 1'b1;
        #1 check("flush_enq", {instr0_enq_valid, instr1_enq_valid}, 2'b00);
        cycle();
        flush_valid = 1'b0; rob_state = 2'b01;
        drive_group(1, rand_ins(0), 1, rand_ins(0));
        for (int i = 0; i < 6; i++) cycle();
        rob_state = 2'b00;
        #1 check("walk_exit_ready", rn_ready, 1'b0);
        cycle();
        #1 check("post_walk_ready", rn_ready, 1'b1);
        cycle();
        drive_group(0, none, 0, none);
        cycle();

        // Reset in the middle of a walk returns straight to RUN.
        drive_group(1, rand_ins(0), 1, rand_ins(0));
        cycle();
        flush_valid = 1'b1; rob_state = 2'b01;
        cycle();
        flush_valid = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        drive_group(0, none, 0, none);
        #1 check("walk_rst_ready", rn_ready, 1'b1);
        cycle();

        // Reset with a full buffer in RUN drops both slots.
        rob_counter = 7'd64;
        drive_group(1, rand_ins(0), 1, rand_ins(0));
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0; rob_counter = 7'd0;
        drive_group(0, none, 0, none);
        #1;
        check("rst_full_enq", {instr0_enq_valid, instr1_enq_valid}, 2'b00);
        check("rst_full_pc0", instr0_pc, 64'd0);
        cycle();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            int r;
            reset       = ($urandom_range(0, 199) == 0);
            flush_valid = ($urandom_range(0, 24) == 0);
            rob_state   = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'b01;
            r = $urandom_range(0, 3);
            rob_counter = (r == 0) ? 7'd64 : (r == 1) ? 7'd63 : 7'($urandom_range(0, ENTRIES));
            iq_can_alloc0 = ($urandom_range(0, 3) != 0);
            iq_can_alloc1 = ($urandom_range(0, 3) != 0);
            sq_can_alloc  = ($urandom_range(0, 3) != 0);
            drive_group(1'($urandom), rand_ins(1), 1'($urandom), rand_ins(1));
            cycle();
        end

`ifdef DISPATCH_PERF_EN
        // Ten IQ-blocked cycles with s0 valid charge only the IQ counter.
        reset = 1'b1; flush_valid = 1'b0; rob_state = 2'b00; rob_counter = '0;
        iq_can_alloc0 = 1'b1; iq_can_alloc1 = 1'b1; sq_can_alloc = 1'b1;
        drive_group(0, none, 0, none);
        cycle();
        reset = 1'b0; iq_can_alloc0 = 1'b0;
        drive_group(1, rand_ins(0), 0, none);
        cycle();
        drive_group(0, none, 0, none);
        for (int i = 0; i < 10; i++) cycle();
        #1;
        check("perf_iq", perf_stall_iq, 64'd10);
        check("perf_rob", perf_stall_rob, 64'd0);
        check("perf_sq", perf_stall_sq, 64'd0);
        iq_can_alloc0 = 1'b1;
        cycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
